// File: rtl/img_stream_gen.sv
// -----------------------------------------------------------------------------
// img_stream_gen
//   Frame-level video stream transmitter. Emits a vsync/href/8-bit gray stream
//   with programmable lead, trail, horizontal blanking and inter-frame gap.
//   Pixels come from a built-in test pattern (H ramp, V ramp, 8x8 checker) or
//   from an external first-word-fall-through pixel FIFO.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   frame_start    single-cycle request for one frame, honoured only in IDLE
//   cont_mode      1 = keep sending frames back-to-back, sampled at GAP exit
//   pattern_sel    0 H ramp, 1 V ramp, 2 checkerboard, 3 external FIFO
//   ext_pix_data   FWFT FIFO head data
//   ext_pix_empty  FWFT FIFO empty flag
//   ext_pix_rd     FIFO pop strobe (combinational from the state register)
//   img_vsync      frame valid
//   img_href       line valid
//   img_gray       pixel value, zero whenever img_href is low
//   busy           high whenever the FSM is not in IDLE
//   frame_done     one-cycle pulse at the end of each frame's GAP
//   underrun       sticky flag: FIFO was empty during an active external pixel
// -----------------------------------------------------------------------------
module img_stream_gen #(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter logic [10:0] H_BLANK   = 11'd16,
    parameter logic [10:0] VS_LEAD   = 11'd4,
    parameter logic [10:0] VS_TRAIL  = 11'd4,
    parameter logic [15:0] FRAME_GAP = 16'd700
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       cont_mode,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] ext_pix_data,
    input  logic       ext_pix_empty,
    output logic       ext_pix_rd,
    output logic       img_vsync,
    output logic       img_href,
    output logic [7:0] img_gray,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        ACTIVE,
        HBLANK,
        TRAIL,
        GAP
    } state_t;

    // Terminal counts; the blanking counters share the 16-bit tcnt.
    localparam logic [10:0] H_LAST     = IMG_HDISP - 11'd1;
    localparam logic [10:0] V_LAST     = IMG_VDISP - 11'd1;
    localparam logic [15:0] LEAD_LAST  = {5'd0, VS_LEAD} - 16'd1;
    localparam logic [15:0] HBLK_LAST  = {5'd0, H_BLANK} - 16'd1;
    localparam logic [15:0] TRAIL_LAST = {5'd0, VS_TRAIL} - 16'd1;
    localparam logic [15:0] GAP_LAST   = FRAME_GAP - 16'd1;

    state_t      state;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [15:0] tcnt;
    logic [1:0]  pat;
    logic [7:0]  pix_val;

    // A pop happens only for a real external pixel; an empty FIFO never stalls
    // the timing, it just produces a zero pixel and flags underrun.
    assign ext_pix_rd = (state == ACTIVE) && (pat == 2'd3) && !ext_pix_empty;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pix_val = 8'h00;
        case (pat)
            2'd0:    pix_val = hcnt[7:0];
            2'd1:    pix_val = vcnt[7:0];
            2'd2:    pix_val = (hcnt[3] ^ vcnt[3]) ? 8'hFF : 8'h00;
            default: pix_val = ext_pix_rd ? ext_pix_data : 8'h00;
        endcase
    end

    // Outputs are computed from the state/counters held during the cycle that
    // ends at this edge, so every output lags the FSM by exactly one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hcnt       <= 11'd0;
            vcnt       <= 11'd0;
            tcnt       <= 16'd0;
            pat        <= 2'd0;
            img_vsync  <= 1'b0;
            img_href   <= 1'b0;
            img_gray   <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            img_vsync  <= (state == LEAD) || (state == ACTIVE) ||
                          (state == HBLANK) || (state == TRAIL);
            img_href   <= (state == ACTIVE);
            img_gray   <= (state == ACTIVE) ? pix_val : 8'h00;
            busy       <= (state != IDLE);
            frame_done <= 1'b0;

            if ((state == ACTIVE) && (pat == 2'd3) && ext_pix_empty) begin
                underrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= LEAD;
                        pat      <= pattern_sel;
                        tcnt     <= 16'd0;
                        underrun <= 1'b0;
                    end
                end
                LEAD: begin
                    if (tcnt == LEAD_LAST) begin
                        state <= ACTIVE;
                        tcnt  <= 16'd0;
                        hcnt  <= 11'd0;
                        vcnt  <= 11'd0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                ACTIVE: begin
                    if (hcnt == H_LAST) begin
                        hcnt  <= 11'd0;
                        tcnt  <= 16'd0;
                        state <= (vcnt < V_LAST) ? HBLANK : TRAIL;
                    end else begin
                        hcnt <= hcnt + 11'd1;
                    end
                end
                HBLANK: begin
                    if (tcnt == HBLK_LAST) begin
                        state <= ACTIVE;
                        tcnt  <= 16'd0;
                        vcnt  <= vcnt + 11'd1;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                TRAIL: begin
                    if (tcnt == TRAIL_LAST) begin
                        state <= GAP;
                        tcnt  <= 16'd0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                GAP: begin
                    if (tcnt == GAP_LAST) begin
                        frame_done <= 1'b1;
                        tcnt       <= 16'd0;
                        // A frame_start arriving here is ignored: only IDLE
                        // accepts requests, continuous mode re-enters LEAD.
                        if (cont_mode) begin
                            state <= LEAD;
                            pat   <= pattern_sel;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
